axi_llc_way_router: RTL

Parametrised request/response interconnect between the LLC's cache units and its data ways. It routes each unit's way request to the way selected by its one-hot `way_ind` through per-way round-robin arbitration. It returns way read responses to a configurable set of response ports in strict per-port request order, using one ordering FIFO per response port. It sits between the unit pipeline (evict, refill, write, read, plus future units such as ATOP) and the array of data-way instances.

---
 rtl/axi_llc_way_router.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_llc_way_router.sv
// axi_llc_way_router: one-hot way routing with per-way round robin and
// per-port ordered read return. Option: AXI_LLC_WAY_ROUTER_STALL_CNT_EN.
package axi_llc_way_router_pkg;
    typedef struct packed {
        logic [7:0]  way_ind;
        logic [31:0] data;
    } way_req_t;
    typedef struct packed {
        logic [1:0]  cache_unit;
        logic [31:0] data;
    } way_rsp_t;
endpackage

module axi_llc_way_router
    import axi_llc_way_router_pkg::*;
#(
    parameter int unsigned         NumUnits  = 4,
    parameter int unsigned         NumWays   = 8,
    parameter logic [NumUnits-1:0] RespMask  = 4'b1001,
    parameter int unsigned         FifoDepth = NumWays + 1,
    parameter type                 req_t     = way_req_t,
    parameter type                 rsp_t     = way_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                test_i,
    input  req_t                unit_req_i [NumUnits-1:0],
    input  logic [NumUnits-1:0] unit_req_valid_i,
    output logic [NumUnits-1:0] unit_req_ready_o,
    output rsp_t                unit_rsp_o [NumUnits-1:0],
    output logic [NumUnits-1:0] unit_rsp_valid_o,
    input  logic [NumUnits-1:0] unit_rsp_ready_i,
    output req_t                way_req_o [NumWays-1:0],
    output logic [NumWays-1:0]  way_req_valid_o,
    input  logic [NumWays-1:0]  way_req_ready_i,
    input  rsp_t                way_rsp_i [NumWays-1:0],
    input  logic [NumWays-1:0]  way_rsp_valid_i,
    output logic [NumWays-1:0]  way_rsp_ready_o,
`ifdef AXI_LLC_WAY_ROUTER_STALL_CNT_EN
    output logic [NumUnits-1:0][31:0] stall_cnt_o,
`endif
    output logic                sel_err_o
);

    localparam int unsigned UnitIdxW = (NumUnits > 1) ? $clog2(NumUnits) : 1;
    localparam int unsigned PtrW     = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW     = $clog2(FifoDepth + 1);

    logic [NumUnits-1:0] legal, arb_valid, req_hit;
    logic [NumUnits-1:0] fifo_full, fifo_empty, push, pop, rsp_hit;
    logic [NumUnits-1:0][NumWays-1:0] fifo_head;
    logic [NumWays-1:0][NumUnits-1:0] cand;
    logic [NumWays-1:0][UnitIdxW-1:0] rr_ptr_q, rr_idx, gnt, lock_unit_q;
    logic [NumWays-1:0] lock_q;
    logic unused_sig;

    assign unused_sig = ^{test_i, unit_rsp_ready_i & ~RespMask};

    always_comb begin
        legal = '0;
        for (int u = 0; u < NumUnits; u++) begin
            legal[u] = $onehot(unit_req_i[u].way_ind);
        end
    end

    // A pop in the same cycle frees the slot for a new push.
    assign arb_valid = unit_req_valid_i & legal
                     & ~(RespMask & fifo_full & ~pop);

    always_comb begin
        cand = '0;
        for (int w = 0; w < NumWays; w++) begin
            for (int u = 0; u < NumUnits; u++) begin
                cand[w][u] = arb_valid[u] & unit_req_i[u].way_ind[w];
            end
        end
    end

    // Lowest candidate at or above the pointer, else lowest overall.
    always_comb begin
        rr_idx = '0;
        for (int w = 0; w < NumWays; w++) begin
            for (int u = NumUnits - 1; u >= 0; u--) begin
                if (cand[w][u]) rr_idx[w] = UnitIdxW'(u);
            end
            for (int u = NumUnits - 1; u >= 0; u--) begin
                if (cand[w][u] && UnitIdxW'(u) >= rr_ptr_q[w]) begin
                    rr_idx[w] = UnitIdxW'(u);
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int w = 0; w < NumWays; w++) begin
            gnt[w] = lock_q[w] ? lock_unit_q[w] : rr_idx[w];
        end
    end

    always_comb begin
        way_req_valid_o = '0;
        for (int w = 0; w < NumWays; w++) begin
            way_req_valid_o[w] = cand[w][gnt[w]];
            way_req_o[w]       = unit_req_i[gnt[w]];
        end
    end

    always_comb begin
        req_hit = '0;
        for (int w = 0; w < NumWays; w++) begin
            if (way_req_valid_o[w] && way_req_ready_i[w]) begin
                req_hit[gnt[w]] = 1'b1;
            end
        end
    end

    assign unit_req_ready_o = req_hit | ~legal;
    assign push             = unit_req_valid_i & req_hit & RespMask;
    assign sel_err_o        = |(unit_req_valid_i & ~legal);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= '0;
            lock_q      <= '0;
            lock_unit_q <= '0;
        end else begin
            for (int w = 0; w < NumWays; w++) begin
                if (way_req_valid_o[w] && way_req_ready_i[w]) begin
                    lock_q[w]   <= 1'b0;
                    rr_ptr_q[w] <= (gnt[w] == UnitIdxW'(NumUnits - 1))
                                 ? '0 : gnt[w] + UnitIdxW'(1);
                end else if (way_req_valid_o[w]) begin
                    lock_q[w]      <= 1'b1;
                    lock_unit_q[w] <= gnt[w];
                end
            end
        end
    end

    for (genvar u = 0; u < NumUnits; u++) begin : g_unit
        if (RespMask[u]) begin : g_fifo
            logic [NumWays-1:0] mem_q [FifoDepth];
            logic [PtrW-1:0]    wr_q, rd_q;
            logic [CntW-1:0]    cnt_q;

            always_ff @(posedge clk_i) begin
                if (push[u]) mem_q[wr_q] <= unit_req_i[u].way_ind;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    wr_q  <= '0;
                    rd_q  <= '0;
                    cnt_q <= '0;
                end else begin
                    if (push[u]) begin
                        wr_q <= (wr_q == PtrW'(FifoDepth - 1))
                              ? '0 : wr_q + PtrW'(1);
                    end
                    if (pop[u]) begin
                        rd_q <= (rd_q == PtrW'(FifoDepth - 1))
                              ? '0 : rd_q + PtrW'(1);
                    end
                    if (push[u] && !pop[u]) cnt_q <= cnt_q + CntW'(1);
                    if (pop[u] && !push[u]) cnt_q <= cnt_q - CntW'(1);
                end
            end

            assign fifo_full[u]  = (cnt_q == CntW'(FifoDepth));
            assign fifo_empty[u] = (cnt_q == '0);
            assign fifo_head[u]  = mem_q[rd_q];
        end else begin : g_nofifo
            assign fifo_full[u]  = 1'b0;
            assign fifo_empty[u] = 1'b1;
            assign fifo_head[u]  = '0;
        end
    end

    // Tag match keeps two ports from claiming the same way.
    always_comb begin
        rsp_hit = '0;
        for (int u = 0; u < NumUnits; u++) begin
            unit_rsp_o[u] = '0;
            if (RespMask[u] && !fifo_empty[u]) begin
                for (int w = 0; w < NumWays; w++) begin
                    if (fifo_head[u][w] && way_rsp_valid_i[w] &&
                        way_rsp_i[w].cache_unit == UnitIdxW'(u)) begin
                        rsp_hit[u]    = 1'b1;
                        unit_rsp_o[u] = way_rsp_i[w];
                    end
                end
            end
        end
    end

    assign unit_rsp_valid_o = rsp_hit;
    assign pop              = rsp_hit & unit_rsp_ready_i;

    always_comb begin
        way_rsp_ready_o = '0;
        for (int u = 0; u < NumUnits; u++) begin
            for (int w = 0; w < NumWays; w++) begin
                if (pop[u] && fifo_head[u][w]) way_rsp_ready_o[w] = 1'b1;
            end
        end
    end

`ifdef AXI_LLC_WAY_ROUTER_STALL_CNT_EN
    logic [NumUnits-1:0][31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            for (int u = 0; u < NumUnits; u++) begin
                if (unit_req_valid_i[u] && !unit_req_ready_o[u] &&
                    stall_q[u] != '1) begin
                    stall_q[u] <= stall_q[u] + 32'd1;
                end
            end
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule
